// File: rtl/slice_cfg_loader.sv
// Configuration sequencer for one fractured-LUT slice: takes bitstream words over a
// valid/ready stream and shifts exactly CHAIN_LEN bits, LSB first, onto the slice config chain.
module slice_cfg_loader #(
   parameter int CFG_WORD_W = 8,
   parameter int CHAIN_LEN  = 139,
   parameter int CNT_W      = $clog2(CHAIN_LEN + 1)
) (
   input  logic                  cclk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic [CFG_WORD_W-1:0] word_data,
   input  logic                  word_valid,
   output logic                  word_ready,
   output logic                  cfg_bit,
   output logic                  cfg_en,
   output logic                  busy,
   output logic                  done,
   output logic                  configured,
   output logic [CNT_W-1:0]      bit_count
);

   localparam int SUB_W = (CFG_WORD_W > 1) ? $clog2(CFG_WORD_W) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [CFG_WORD_W-1:0] shreg_q, shreg_d;
   logic [SUB_W-1:0]      sub_q, sub_d;
   logic [CNT_W-1:0]      bit_count_q, bit_count_d;
   logic                  configured_q, configured_d;

   logic last_bit;
   logic last_in_word;

   assign last_bit     = (bit_count_q == CNT_W'(CHAIN_LEN - 1));
   assign last_in_word = (sub_q == SUB_W'(CFG_WORD_W - 1));

   // Abort wins over both the word handshake and the final-bit exit.
   always_comb begin
      state_d      = state_q;
      shreg_d      = shreg_q;
      sub_d        = sub_q;
      bit_count_d  = bit_count_q;
      configured_d = configured_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d      = LOAD;
               bit_count_d  = '0;
               configured_d = 1'b0;
            end
         end
         LOAD: begin
            if (abort) begin
               state_d      = IDLE;
               bit_count_d  = '0;
               configured_d = 1'b0;
            end else if (word_valid) begin
               shreg_d = word_data;
               sub_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (abort) begin
               state_d      = IDLE;
               bit_count_d  = '0;
               configured_d = 1'b0;
            end else begin
               shreg_d = shreg_q >> 1;
               sub_d   = sub_q + SUB_W'(1);
               if (bit_count_q < CNT_W'(CHAIN_LEN)) begin
                  bit_count_d = bit_count_q + CNT_W'(1);
               end
               if (last_bit) begin
                  state_d = DONE;
               end else if (last_in_word) begin
                  state_d = LOAD;
               end
            end
         end
         DONE: begin
            configured_d = 1'b1;
            state_d      = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge cclk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         shreg_q      <= '0;
         sub_q        <= '0;
         bit_count_q  <= '0;
         configured_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         shreg_q      <= shreg_d;
         sub_q        <= sub_d;
         bit_count_q  <= bit_count_d;
         configured_q <= configured_d;
      end
   end

   // Outputs decode only the state register, so the chain never sees an input-driven glitch.
   assign word_ready = (state_q == LOAD);
   assign cfg_en     = (state_q == SHIFT);
   assign cfg_bit    = (state_q == SHIFT) & shreg_q[0];
   assign busy       = (state_q == LOAD) | (state_q == SHIFT);
   assign done       = (state_q == DONE);
   assign configured = configured_q;
   assign bit_count  = bit_count_q;

endmodule

// File: tb/tb_slice_cfg_loader.sv
// Randomized bench for slice_cfg_loader: the expected chain image, latency and bit count
// come from the bitstream words and handshake counts, not from the loader's internals.
module tb_slice_cfg_loader;

   localparam int W      = 8;
   localparam int LEN    = 139;
   localparam int CNT_W  = $clog2(LEN + 1);
   localparam int NWORDS = (LEN + W - 1) / W;

   logic             cclk = 1'b0;
   logic             rst;
   logic             start;
   logic             abort;
   logic [W-1:0]     word_data;
   logic             word_valid;
   logic             word_ready;
   logic             cfg_bit;
   logic             cfg_en;
   logic             busy;
   logic             done;
   logic             configured;
   logic [CNT_W-1:0] bit_count;

   int vectors     = 0;
   int miscompares = 0;

   logic [W-1:0] words [NWORDS];
   bit           chain_q [$];

   slice_cfg_loader #(.CFG_WORD_W(W), .CHAIN_LEN(LEN)) dut (
      .cclk       (cclk),
      .rst        (rst),
      .start      (start),
      .abort      (abort),
      .word_data  (word_data),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .cfg_bit    (cfg_bit),
      .cfg_en     (cfg_en),
      .busy       (busy),
      .done       (done),
      .configured (configured),
      .bit_count  (bit_count)
   );

   always #5 cclk = ~cclk;

   // The slice chain as seen from outside: every enabled cycle shifts in one bit.
   always @(negedge cclk) begin
      if (!rst && cfg_en) chain_q.push_back(cfg_bit);
   end

   task automatic check_output(input string tag, input logic [159:0] observed,
                               input logic [159:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // One complete load; abort_bit < 0 disables abort, stall_len cycles of no-valid in LOAD for stall_word.
   task automatic apply_stimulus(input bit new_words, input bit last_ff, input int stall_word,
                                 input int stall_len, input int abort_bit, input bit poke_start);
      logic [159:0] exp_img;
      logic [159:0] got_img;
      int cycles, w, stall_left, nb, done_cycle, exp_done;
      bit done_seen, aborted, late_done;
      if (new_words) begin
         for (int i = 0; i < NWORDS; i++) words[i] = W'($urandom_range(0, 255));
      end
      if (last_ff) words[NWORDS-1] = 8'hFF;
      exp_img = '0;
      for (int b = 0; b < LEN; b++) exp_img[b] = words[b / W][b % W];
      exp_done = NWORDS + stall_len + LEN + 1;
      chain_q.delete();

      @(posedge cclk); #1;
      start = 1'b1;
      word_valid = 1'b0;
      @(posedge cclk); #1;
      start = 1'b0;
      cycles = 1; w = 0; stall_left = stall_len;
      done_seen = 0; aborted = 0; done_cycle = -1;
      while (!done_seen && !aborted && cycles < 400) begin
         nb = chain_q.size();
         word_valid = (w < NWORDS) && !(w == stall_word && stall_left > 0);
         word_data  = words[(w < NWORDS) ? w : 0];
         abort      = (abort_bit >= 0) && (nb == abort_bit);
         start      = poke_start && (cycles == 40 || cycles == exp_done);
         @(negedge cclk);
         check_output("bit_count", 160'(bit_count), 160'(nb));
         if (cycles == 1) begin
            check_output("load_ready", 160'(word_ready), 160'(1));
            check_output("cfg_cleared", 160'(configured), 160'(0));
         end
         if (word_ready && word_valid) begin
            w++;
         end else if (word_ready && w == stall_word && stall_left > 0) begin
            stall_left--;
            check_output("stall_cfg_en", 160'(cfg_en), 160'(0));
         end
         if (done) begin
            done_seen  = 1;
            done_cycle = cycles;
            check_output("done_cfg_en", 160'(cfg_en), 160'(0));
         end
         if (abort) aborted = 1;
         @(posedge cclk); #1;
         cycles++;
      end
      abort = 1'b0;
      start = 1'b0;
      word_valid = 1'b0;

      if (abort_bit >= 0) begin
         check_output("abort_taken", 160'(aborted), 160'(1));
         @(negedge cclk);
         check_output("abort_busy", 160'(busy), 160'(0));
         check_output("abort_count", 160'(bit_count), 160'(0));
         check_output("abort_cfgd", 160'(configured), 160'(0));
         late_done = done;
         for (int k = 0; k < 5; k++) begin
            @(negedge cclk);
            late_done = late_done | done;
         end
         check_output("abort_no_done", 160'(late_done), 160'(0));
      end else begin
         check_output("done_seen", 160'(done_seen), 160'(1));
         check_output("latency", 160'(done_cycle), 160'(exp_done));
         @(negedge cclk);
         check_output("configured", 160'(configured), 160'(1));
         check_output("idle_busy", 160'(busy), 160'(0));
         check_output("final_count", 160'(bit_count), 160'(LEN));
         check_output("chain_len", 160'(chain_q.size()), 160'(LEN));
         got_img = '0;
         for (int b = 0; b < chain_q.size() && b < 160; b++) got_img[b] = chain_q[b];
         check_output("chain_image", got_img, exp_img);
         if (poke_start) begin
            @(negedge cclk);
            check_output("start_ignored", 160'(busy), 160'(0));
         end
      end
   endtask

   task automatic reset_mid_shift();
      for (int i = 0; i < NWORDS; i++) words[i] = W'($urandom_range(0, 255));
      @(posedge cclk); #1;
      start = 1'b1;
      @(posedge cclk); #1;
      start = 1'b0;
      word_valid = 1'b1;
      word_data  = words[0];
      repeat (30) @(posedge cclk);
      @(negedge cclk);
      check_output("pre_rst_shift", 160'(cfg_en), 160'(1));
      #2 rst = 1'b1;
      #1;
      check_output("rst_async_outs",
                   160'({word_ready, cfg_bit, cfg_en, busy, done, configured, bit_count}), 160'(0));
      word_valid = 1'b0;
      @(negedge cclk);
      rst = 1'b0;
      @(negedge cclk);
      check_output("rst_stays_idle", 160'({busy, cfg_en}), 160'(0));
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      word_valid = 1'b0;
      word_data = '0;
      #12;
      check_output("reset_outs",
                   160'({word_ready, cfg_bit, cfg_en, busy, done, configured, bit_count}), 160'(0));
      @(negedge cclk);
      rst = 1'b0;

      apply_stimulus(1, 0, -1, 0, -1, 0);
      apply_stimulus(0, 0, 7, 5, -1, 0);
      apply_stimulus(1, 1, -1, 0, -1, 0);
      apply_stimulus(1, 0, -1, 0, 50, 0);
      apply_stimulus(0, 0, -1, 0, -1, 0);
      apply_stimulus(1, 0, -1, 0, -1, 1);
      reset_mid_shift();
      for (int r = 0; r < 4; r++) begin
         apply_stimulus(1, 0, $urandom_range(0, NWORDS - 1), $urandom_range(0, 6), -1, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
